// File: rtl/dcache_wb_buffer.sv
// Write-back buffer between the data cache controller and the memory bus.
// Holds evicted dirty blocks in a circular FIFO and drains them as BUS_STORE.
// Shares the bus port with controller loads, and forwards pending data to
// loads that hit a buffered block.

package dcache_wb_pkg;
    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;
endpackage

module dcache_wb_buffer
    import dcache_wb_pkg::*;
#(
    parameter int BLOCK_W = 64,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               evict_valid,
    input  logic [63:0]        evict_addr,
    input  logic [BLOCK_W-1:0] evict_data,
    output logic               evict_ready,
    input  logic               ld_valid,
    input  logic [63:0]        ld_addr,
    output logic               ld_grant,
    output logic [3:0]         ld_response,
    output logic               fwd_hit,
    output logic [BLOCK_W-1:0] fwd_data,
    input  logic               flush,
    output logic               flush_done,
    input  logic [3:0]         Dmem2proc_response,
    output BUS_COMMAND         proc2Dmem_command,
    output logic [63:0]        proc2Dmem_addr,
    output logic [BLOCK_W-1:0] proc2Dmem_data,
    output logic [CNT_W-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_NORMAL = 2'd0,
        S_FORCE  = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [63:0]        r_addr [DEPTH];
    logic [BLOCK_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_next;
    logic               r_flush_done;
    logic               r_flush_block;
    logic               w_push;
    logic               w_pop;
    logic               w_load;
    logic               w_store;
    logic               w_flush_req;
    logic               w_done;
    logic               w_fwd_hit;
    logic [BLOCK_W-1:0] w_fwd_data;
    logic [PTR_W-1:0]   w_idx;

    assign w_push = evict_valid && (r_count < CNT_W'(DEPTH));
    assign w_pop  = w_store && (Dmem2proc_response != 4'd0);
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_flush_req  = flush && !r_flush_block;

    // Scan valid entries oldest to youngest so the last match (youngest) wins.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        w_idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PTR_W'(k);
            if ((CNT_W'(k) < r_count) && (r_addr[w_idx][63:3] == ld_addr[63:3])) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_data[w_idx];
            end
        end
    end

    // Pick the single bus command for this cycle: loads only in NORMAL, otherwise drain the head.
    always_comb begin
        w_load            = 1'b0;
        w_store           = 1'b0;
        proc2Dmem_command = BUS_NONE;
        proc2Dmem_addr    = '0;
        proc2Dmem_data    = '0;
        if ((r_state == S_NORMAL) && ld_valid && !w_fwd_hit) begin
            w_load            = 1'b1;
            proc2Dmem_command = BUS_LOAD;
            proc2Dmem_addr    = ld_addr;
        end else if (r_count != '0) begin
            w_store           = 1'b1;
            proc2Dmem_command = BUS_STORE;
            proc2Dmem_addr    = r_addr[r_head];
            proc2Dmem_data    = r_data[r_head];
        end
    end

    // Arbitration mode transitions; FLUSH exits once the buffer is seen empty at an edge.
    always_comb begin
        w_state_next = r_state;
        w_done       = 1'b0;
        case (r_state)
            S_NORMAL: begin
                if (w_flush_req) begin
                    w_state_next = S_FLUSH;
                end else if (w_count_next == CNT_W'(DEPTH)) begin
                    w_state_next = S_FORCE;
                end
            end
            S_FORCE: begin
                if (w_flush_req) begin
                    w_state_next = S_FLUSH;
                end else if (w_count_next <= CNT_W'(DEPTH / 2)) begin
                    w_state_next = S_NORMAL;
                end
            end
            S_FLUSH: begin
                if (r_count == '0) begin
                    w_done       = 1'b1;
                    w_state_next = S_NORMAL;
                end
            end
            default: w_state_next = S_NORMAL;
        endcase
    end

    // Control state: mode, pointers, occupancy and the flush handshake.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_NORMAL;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_flush_done  <= 1'b0;
            r_flush_block <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_count      <= w_count_next;
            r_flush_done <= w_done;
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            // A held flush level must drop before it can start another drain.
            r_flush_block <= w_done ? flush : (r_flush_block && flush);
        end
    end

    // Entry storage needs no reset: only entries covered by count are ever observed.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_addr[r_tail] <= evict_addr & ~64'h7;
            r_data[r_tail] <= evict_data;
        end
    end

    assign evict_ready = (r_count < CNT_W'(DEPTH));
    assign ld_grant    = w_load;
    assign ld_response = w_load ? Dmem2proc_response : 4'd0;
    assign fwd_hit     = w_fwd_hit;
    assign fwd_data    = w_fwd_data;
    assign flush_done  = r_flush_done;
    assign count       = r_count;

endmodule
